ioshim_seq: RTL and testbench
=============================

Name: ioshim_seq

Overview:
- Pin-sequencer that fetches 16-bit instruction words from the read-only port of the ioshim dual-port word memory (addr2/rdata2) and executes them to drive I/O pins.
- Supports pin writes, output-enable writes, cycle delays, wait-on-input, jumps and halt.
- The host loads programs through the memory's write port, then pulses start.
- Sits directly downstream of the memory. Owns addr2; consumes rdata2, which has a 1-cycle registered latency.

Parameters:
- NPINS, 8, number of I/O pins; fixed at 8 by the instruction encoding. Elaboration error if changed.
- SYNC_STAGES, 2, depth of the pins_in synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to start execution at start_addr; ignored unless idle.
- start_addr  input  11  first instruction word address.
- abort  input  1  synchronous stop; returns to IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when HALT executes.
- mem_addr  output  11  to memory addr2; equals the pc register.
- mem_rdata  input  16  from memory rdata2.
- pins_in  input  8  asynchronous pin inputs.
- pins_out  output  8  registered output values.
- pins_oe  output  8  registered output enables.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE.
  - pc, mem_addr, pins_out, pins_oe, busy, done, counter and sync flops all 0.
  - Reset overrides start and abort.
- Instruction encoding, opcode = word[15:14]:
  - 00 OUT: if word[13]=0, pins_out<=word[7:0]; else pins_oe<=word[7:0]. Then pc+1.
  - 01 WAIT: idle word[13:0] extra cycles, then pc+1. n=0 behaves like a NOP.
  - 10 JUMP: pc<=word[10:0]. Bits 13:11 are ignored.
  - 11, word[13]=1, WAITIN: stall until sync(pins_in)[word[2:0]]==word[3], then pc+1.
  - 11, word[13]=0, HALT: done=1 for one cycle, then IDLE. pc is held.
- States: IDLE, FETCH, EXEC, WAIT, WAITIN.
  - IDLE: when start=1, pc<=start_addr and go to FETCH.
  - FETCH: the memory samples mem_addr this edge; go to EXEC.
  - EXEC: decode mem_rdata and apply the instruction effect on this edge.
    - OUT, JUMP, WAIT with n=0: go to FETCH.
    - WAIT with n>0: counter<=n, go to WAIT.
    - WAITIN: go to WAITIN.
    - HALT: go to IDLE.
  - WAIT: counter decrements each cycle; when counter==1, pc<=pc+1 and go to FETCH. The block spends exactly n cycles in WAIT.
  - WAITIN: compare every cycle; on match, pc<=pc+1 and go to FETCH. The condition is re-evaluated; it is not latched.
- Timing:
  - start is sampled at edge E0.
  - The first effect appears at edge E2.
  - Back-to-back OUTs update pins every 2 cycles.
  - WAIT n adds n cycles between effects (effect spacing 2+2+n = 4+n from OUT to the next OUT).
- pc increments wrap modulo 2048 (2047 -> 0).
- mem_addr is the pc register. It is not combinational from state.
- abort in any non-IDLE state: go to IDLE next edge. pins_out and pins_oe keep their values. No done pulse. abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- The synchronizer adds SYNC_STAGES cycles of latency to pins_in before WAITIN sees it.
- busy is registered: it rises the cycle after start is accepted and falls in the same cycle done pulses.

Decomposition:
- Package ioshim_pkg:
  - opcode constants OP_OUT, OP_WAIT, OP_JUMP, OP_SYS.
  - state enum seq_state_t.
  - field position constants.
  - ADDR_W=11, WORD_W=16.
- Sub-module ioshim_sync: parameterised multi-stage flop synchronizer for pins_in, resetting to 0 synchronously.
- All other logic lives in one module.

Test Plan:
- Memory words [0]=0x00A5, [1]=0x20FF, [2]=0xC000; start_addr=0 -> pins_out=0xA5 at E2, pins_oe=0xFF at E4, done pulse at E6, busy low at E6, mem_addr held at 2.
- Words [0]=0x4003 (WAIT 3), [1]=0x0001, [2]=0xC000 -> pins_out=0x01 exactly 7 edges after start is sampled. A WAIT 0 variant gives 4 edges.
- Words [0]=0xE00D (WAITIN pin 5 == 1), [1]=0x0077, [2]=0xC000; pins_in[5] held 0 for 20 cycles then set 1 -> pins_out remains 0 until SYNC_STAGES+2 edges after the rise, then 0x77.
- start_addr=2047, word[2047]=0x0011, word[0]=0xC000 -> pc wraps to 0, pins_out=0x11, done pulse.
- Words [5]=0x4FFF, start_addr=5; abort 10 cycles later -> IDLE next edge, busy=0, no done pulse, pins unchanged. A start pulse during the WAIT is ignored.
- Mid-program resetn=0 for one edge -> all outputs 0 and IDLE. Words [0]=0x8000 (JUMP 0) loop; a pulse on start while busy is ignored.

Source files
------------

// File: rtl/ioshim_pkg.sv
// Shared encoding for the ioshim pin sequencer: opcodes, field positions, FSM states.
package ioshim_pkg;
  localparam int ADDR_W = 11;
  localparam int WORD_W = 16;

  localparam logic [1:0] OP_OUT  = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;

  // Field positions within an instruction word
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 14;
  localparam int SEL_BIT = 13;
  localparam int CNT_HI  = 13;
  localparam int DAT_HI  = 7;
  localparam int JMP_HI  = 10;
  localparam int PIN_HI  = 2;
  localparam int LVL_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_WAITIN
  } seq_state_t;
endpackage

// File: rtl/ioshim_seq_if.sv
// Read-port link between the sequencer and the ioshim word memory (addr2/rdata2).
interface ioshim_seq_if;
  import ioshim_pkg::*;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/ioshim_sync.sv
// Multi-stage flop synchronizer; all stages clear on synchronous reset.
module ioshim_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (STAGES < 2) begin : g_bad_stages
    $error("ioshim_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk) begin
    if (!resetn) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/ioshim_seq.sv
// Pin sequencer: fetches words from the memory read port and executes OUT/WAIT/JUMP/WAITIN/HALT.
module ioshim_seq
  import ioshim_pkg::*;
#(
  parameter int NPINS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  ioshim_seq_if.master      mem,
  input  logic [NPINS-1:0]  pins_in,
  output logic [NPINS-1:0]  pins_out,
  output logic [NPINS-1:0]  pins_oe
);
  if (NPINS != 8) begin : g_bad_npins
    $error("ioshim_seq: NPINS is fixed at 8 by the instruction encoding");
  end

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [CNT_HI:0]   cnt, cnt_n;
  logic [NPINS-1:0]  out_n, oe_n, pins_sync;
  logic              done_n;
  logic [WORD_W-1:0] w;
  logic [1:0]        op;

  ioshim_sync #(.W(NPINS), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pins_in),
    .q      (pins_sync)
  );

  assign w  = mem.mem_rdata;
  assign op = w[OP_HI:OP_LO];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= '0;
      cnt      <= '0;
      pins_out <= '0;
      pins_oe  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      pins_out <= out_n;
      pins_oe  <= oe_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    out_n   = pins_out;
    oe_n    = pins_oe;
    done_n  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        pc_n    = start_addr;
        state_n = S_FETCH;
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: case (op)
        OP_OUT: begin
          if (w[SEL_BIT]) oe_n  = w[DAT_HI:0];
          else            out_n = w[DAT_HI:0];
          pc_n    = pc + ADDR_W'(1);
          state_n = S_FETCH;
        end
        OP_WAIT: begin
          if (w[CNT_HI:0] == '0) begin
            pc_n    = pc + ADDR_W'(1);
            state_n = S_FETCH;
          end else begin
            cnt_n   = w[CNT_HI:0];
            state_n = S_WAIT;
          end
        end
        OP_JUMP: begin
          pc_n    = w[JMP_HI:0];
          state_n = S_FETCH;
        end
        default: begin
          if (w[SEL_BIT]) state_n = S_WAITIN;
          else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      endcase
      S_WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == 14'd1) begin
          pc_n    = pc + ADDR_W'(1);
          state_n = S_FETCH;
        end
      end
      S_WAITIN: if (pins_sync[w[PIN_HI:0]] == w[LVL_BIT]) begin
        pc_n    = pc + ADDR_W'(1);
        state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
    // Abort freezes everything except the state; pins and pc keep their values.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      pc_n    = pc;
      cnt_n   = cnt;
      out_n   = pins_out;
      oe_n    = pins_oe;
      done_n  = 1'b0;
    end
  end

  assign mem.mem_addr = pc;
endmodule

// File: tb/tb_ioshim_seq.sv
// Bench for ioshim_seq: directed scenarios plus random programs against an instruction-level timing model.
module tb_ioshim_seq;
  import ioshim_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              abort = 1'b0;
  logic              busy, done;
  logic [7:0]        pins_in = '0;
  logic [7:0]        pins_out, pins_oe;

  logic [15:0] mem [2048];
  int n_chk = 0;
  int n_fail = 0;

  ioshim_seq_if bus ();

  ioshim_seq #(.NPINS(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem        (bus.master),
    .pins_in    (pins_in),
    .pins_out   (pins_out),
    .pins_oe    (pins_oe)
  );

  always #5 clk = ~clk;

  // Registered read port with one cycle of latency
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hC000;
  endtask

  // Edge E0: start sampled
  task automatic go(input logic [ADDR_W-1:0] a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Random program model: effects by edge number relative to E0
  bit         eff_v [512];
  logic [7:0] eff_o [512];
  logic [7:0] eff_e [512];

  task automatic rand_prog(output int t_done, output logic [10:0] base);
    logic [10:0] a;
    logic [7:0]  o, e, d;
    int t, n, kind, cnt;
    for (int i = 0; i < 512; i++) eff_v[i] = 1'b0;
    base = 11'($urandom_range(0, 2047));
    a = base; t = 2; o = 8'h00; e = 8'h00;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      d = 8'($urandom);
      case (kind)
        0: begin
          mem[a] = {8'h00, d}; o = d;
          eff_v[t] = 1'b1; eff_o[t] = o; eff_e[t] = e;
          a = a + 11'd1; t += 2;
        end
        1: begin
          mem[a] = {8'h20, d}; e = d;
          eff_v[t] = 1'b1; eff_o[t] = o; eff_e[t] = e;
          a = a + 11'd1; t += 2;
        end
        2: begin
          cnt = $urandom_range(0, 5);
          mem[a] = 16'h4000 | 16'(cnt);
          a = a + 11'd1; t += 2 + cnt;
        end
        default: begin
          mem[a] = 16'h8000 | (16'($urandom_range(0, 7)) << 11) | 16'(11'(a + 11'd2));
          mem[11'(a + 11'd1)] = 16'h00EE;
          a = a + 11'd2; t += 2;
        end
      endcase
    end
    mem[a] = 16'hC000;
    t_done = t;
  endtask

  initial begin
    int t_done;
    logic [10:0] base;
    logic [7:0] xo, xe;
    int seen;

    clear_mem();
    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", pins_out, 0);
    chk("rst_oe", pins_oe, 0);
    chk("rst_addr", bus.mem_addr, 0);

    // OUT, OE, HALT
    mem[0] = 16'h00A5; mem[1] = 16'h20FF; mem[2] = 16'hC000;
    go(0);
    chk("t1_busy_e0", busy, 1);
    tick();
    chk("t1_out_e1", pins_out, 8'h00);
    tick();
    chk("t1_out_e2", pins_out, 8'hA5);
    ticks(1);
    chk("t1_oe_e3", pins_oe, 8'h00);
    tick();
    chk("t1_oe_e4", pins_oe, 8'hFF);
    tick();
    chk("t1_done_e5", done, 0);
    tick();
    chk("t1_done_e6", done, 1);
    chk("t1_busy_e6", busy, 0);
    chk("t1_addr_e6", bus.mem_addr, 2);
    tick();
    chk("t1_done_e7", done, 0);

    // WAIT 3 then OUT
    do_reset(); clear_mem();
    mem[0] = 16'h4003; mem[1] = 16'h0001; mem[2] = 16'hC000;
    go(0);
    ticks(6);
    chk("t2_out_e6", pins_out, 8'h00);
    tick();
    chk("t2_out_e7", pins_out, 8'h01);

    // WAIT 0 behaves like a NOP
    do_reset();
    mem[0] = 16'h4000;
    go(0);
    ticks(3);
    chk("t2b_out_e3", pins_out, 8'h00);
    tick();
    chk("t2b_out_e4", pins_out, 8'h01);

    // WAITIN pin 5 == 1
    do_reset(); clear_mem();
    mem[0] = 16'hE00D; mem[1] = 16'h0077; mem[2] = 16'hC000;
    pins_in = 8'h00;
    go(0);
    ticks(20);
    chk("t3_stall_out", pins_out, 8'h00);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_addr", bus.mem_addr, 0);
    pins_in[5] = 1'b1;
    ticks(SYNC_STAGES + 2);
    chk("t3_out_before", pins_out, 8'h00);
    tick();
    chk("t3_out_after", pins_out, 8'h77);
    ticks(2);
    chk("t3_done", done, 1);
    pins_in = 8'h00;

    // pc wrap 2047 -> 0
    do_reset(); clear_mem();
    mem[2047] = 16'h0011; mem[0] = 16'hC000;
    go(11'd2047);
    ticks(2);
    chk("t4_out", pins_out, 8'h11);
    chk("t4_addr", bus.mem_addr, 0);
    ticks(2);
    chk("t4_done", done, 1);
    chk("t4_addr_held", bus.mem_addr, 0);

    // Abort during a long WAIT; start while busy ignored
    do_reset(); clear_mem();
    mem[3] = 16'h00C3; mem[4] = 16'h203C; mem[5] = 16'h4FFF;
    go(3);
    ticks(7);
    start_addr = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_start_ign_addr", bus.mem_addr, 5);
    chk("t5_busy", busy, 1);
    ticks(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_out", pins_out, 8'hC3);
    chk("t5_abort_oe", pins_oe, 8'h3C);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("t5_stays_idle", seen, 0);

    // start and abort together in IDLE: start wins
    do_reset(); clear_mem();
    mem[0] = 16'h0042;
    start_addr = 0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5b_busy", busy, 1);
    ticks(2);
    chk("t5b_out", pins_out, 8'h42);

    // JUMP loop, start while busy, mid-program reset
    do_reset(); clear_mem();
    mem[0] = 16'h00FF; mem[1] = 16'h20FF; mem[2] = 16'h8002;
    go(0);
    ticks(6);
    chk("t6_out", pins_out, 8'hFF);
    chk("t6_oe", pins_oe, 8'hFF);
    start_addr = 11'd100; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    chk("t6_loop_addr", bus.mem_addr, 2);
    chk("t6_loop_busy", busy, 1);
    do_reset();
    chk("t6_rst_out", pins_out, 0);
    chk("t6_rst_oe", pins_oe, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", bus.mem_addr, 0);
    tick();
    chk("t6_rst_idle", busy, 0);

    // Random programs of OUT/OE/WAIT/JUMP ending in HALT
    for (int r = 0; r < 6; r++) begin
      do_reset(); clear_mem();
      rand_prog(t_done, base);
      xo = 8'h00; xe = 8'h00;
      go(base);
      for (int k = 1; k <= t_done; k++) begin
        tick();
        if (eff_v[k]) begin
          xo = eff_o[k]; xe = eff_e[k];
        end
        chk($sformatf("r%0d_out_e%0d", r, k), pins_out, xo);
        chk($sformatf("r%0d_oe_e%0d", r, k), pins_oe, xe);
        chk($sformatf("r%0d_done_e%0d", r, k), done, (k == t_done) ? 1 : 0);
      end
      chk($sformatf("r%0d_busy_end", r), busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
